// File: rtl/ttc3_ctr_pkg.sv
// Shared types and helpers for the SPECK CTR stream engine: FSM state codes, rotation amounts, rotates.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ttc3_ctr_pkg;

  // FSM state codes, kept as plain constants so older tools and dumps see fixed encodings
  typedef logic [2:0] ctr_state_e;
  localparam ctr_state_e ST_IDLE    = 3'd0;
  localparam ctr_state_e ST_KSGEN   = 3'd1;
  localparam ctr_state_e ST_WAIT_IN = 3'd2;
  localparam ctr_state_e ST_OUT     = 3'd3;
  localparam ctr_state_e ST_ZEROIZE = 3'd4;
  localparam ctr_state_e ST_DONE    = 3'd5;

  // Widest SPECK word handled by the rotate helpers
  localparam int ROT_MAX_W = 32;

  // Right-rotation amount (alpha) for a given word width
  function automatic int rot_a(input int word_w);
    return (word_w == 16) ? 7 : 8;
  endfunction

  // Left-rotation amount (beta) for a given word width
  function automatic int rot_b(input int word_w);
    return (word_w == 16) ? 2 : 3;
  endfunction

  // Rotate right by sh within the low w bits of v
  function automatic logic [ROT_MAX_W-1:0] ror_w(input logic [ROT_MAX_W-1:0] v, input int sh, input int w);
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] vm;
    mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
    vm   = v & mask;
    return ((vm >> sh) | (vm << (w - sh))) & mask;
  endfunction

  // Rotate left by sh within the low w bits of v
  function automatic logic [ROT_MAX_W-1:0] rol_w(input logic [ROT_MAX_W-1:0] v, input int sh, input int w);
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] vm;
    mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
    vm   = v & mask;
    return ((vm << sh) | (vm >> (w - sh))) & mask;
  endfunction

endpackage

// File: rtl/ttc3_speck_round.sv
// One SPECK encryption round plus one key-schedule step, purely combinational.
// Latency: 0 cycles (caller registers the results once per cycle).
// Backpressure: none; the caller decides when to take the outputs.
module ttc3_speck_round
  import ttc3_ctr_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k,
  input  logic [WORD_W-1:0] l0,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next,
  output logic [WORD_W-1:0] k_next,
  output logic [WORD_W-1:0] l_next
);

  localparam int ROT_A = rot_a(WORD_W);
  localparam int ROT_B = rot_b(WORD_W);

  logic [ROT_MAX_W-1:0] x_ror;
  logic [ROT_MAX_W-1:0] y_rol;
  logic [ROT_MAX_W-1:0] l0_ror;
  logic [ROT_MAX_W-1:0] k_rol;

  assign x_ror  = ror_w(ROT_MAX_W'(x),  ROT_A, WORD_W);
  assign y_rol  = rol_w(ROT_MAX_W'(y),  ROT_B, WORD_W);
  assign l0_ror = ror_w(ROT_MAX_W'(l0), ROT_A, WORD_W);
  assign k_rol  = rol_w(ROT_MAX_W'(k),  ROT_B, WORD_W);

  // Data round uses the current round key; the schedule step produces the next one
  assign x_next = (x_ror[WORD_W-1:0] + y) ^ k;
  assign y_next = y_rol[WORD_W-1:0] ^ x_next;
  assign l_next = (k + l0_ror[WORD_W-1:0]) ^ WORD_W'(idx);
  assign k_next = k_rol[WORD_W-1:0] ^ l_next;

endmodule

// File: rtl/ttc3_ctr_stream.sv
// Multi-block SPECK CTR stream engine (1 round/cycle); build option TTC3_CTR_WRAP_ALLOW_EN lets the counter wrap.
// Latency: ROUNDS cycles keystream + >=1 cycle input wait + >=1 cycle output hold per block (ROUNDS+2 when streaming).
// Backpressure: in_ready only while waiting for a block; out_data held stable until out_ready; abort overrides both.
module ttc3_ctr_stream
  import ttc3_ctr_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ROUNDS     = 27,
  parameter int MAX_BLOCKS = 16,
  localparam int BLK_W     = 2 * WORD_W,
  localparam int KEY_W     = 4 * WORD_W,
  localparam int CNT_W     = $clog2(MAX_BLOCKS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] ctr_init,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             abort,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RND_W = $clog2(ROUNDS);

  ctr_state_e        state_q;
  ctr_state_e        state_d;
  logic [KEY_W-1:0]  key_q;
  logic [WORD_W-1:0] x_q, y_q, k_q, l0_q, l1_q, l2_q;
  logic [RND_W-1:0]  rnd_q;
  logic [BLK_W-1:0]  ctr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [BLK_W-1:0]  out_q;
  logic              err_q;

  logic [WORD_W-1:0] x_nxt, y_nxt, k_nxt, l_nxt;
  logic [BLK_W-1:0]  ctr_inc;
  logic              num_ok;
  logic              accept, step, take_in, adv, zero, err_set;

  assign ctr_inc = ctr_q + BLK_W'(1);
  assign num_ok  = (num_blocks != '0) && (num_blocks <= CNT_W'(MAX_BLOCKS));

  ttc3_speck_round #(
    .WORD_W (WORD_W),
    .IDX_W  (RND_W)
  ) u_round (
    .x      (x_q),
    .y      (y_q),
    .k      (k_q),
    .l0     (l0_q),
    .idx    (rnd_q),
    .x_next (x_nxt),
    .y_next (y_nxt),
    .k_next (k_nxt),
    .l_next (l_nxt)
  );

  // Next-state and datapath strobes; abort in any busy state wins over every handshake
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    take_in = 1'b0;
    adv     = 1'b0;
    zero    = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_ok) begin
            accept  = 1'b1;
            state_d = ST_KSGEN;
          end else begin
            err_set = 1'b1;
            state_d = ST_ZEROIZE;
          end
        end
      end
      ST_KSGEN: begin
        step = 1'b1;
        if (rnd_q == RND_W'(ROUNDS - 1)) state_d = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          take_in = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          adv = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_ZEROIZE;
          end else if (ctr_q == '1) begin
`ifdef TTC3_CTR_WRAP_ALLOW_EN
            state_d = ST_KSGEN;
`else
            err_set = 1'b1;
            state_d = ST_ZEROIZE;
`endif
          end else begin
            state_d = ST_KSGEN;
          end
        end
      end
      ST_ZEROIZE: begin
        zero    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_ZEROIZE;
      step    = 1'b0;
      take_in = 1'b0;
      adv     = 1'b0;
      err_set = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Key, schedule, keystream, counter and output registers; zeroize clears all secrets at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q <= '0; ctr_q <= '0; rem_q <= '0; rnd_q <= '0; out_q <= '0;
      x_q <= '0; y_q <= '0; k_q <= '0; l0_q <= '0; l1_q <= '0; l2_q <= '0;
    end else if (zero) begin
      key_q <= '0; ctr_q <= '0; rem_q <= '0; rnd_q <= '0; out_q <= '0;
      x_q <= '0; y_q <= '0; k_q <= '0; l0_q <= '0; l1_q <= '0; l2_q <= '0;
    end else begin
      if (accept) begin
        key_q      <= key;
        ctr_q      <= ctr_init;
        rem_q      <= num_blocks;
        {x_q, y_q} <= ctr_init;
        k_q        <= key[WORD_W-1:0];
        l0_q       <= key[2*WORD_W-1:WORD_W];
        l1_q       <= key[3*WORD_W-1:2*WORD_W];
        l2_q       <= key[4*WORD_W-1:3*WORD_W];
        rnd_q      <= '0;
      end else if (adv) begin
        // Preload the next block's counter and the original key so KSGEN starts clean
        ctr_q      <= ctr_inc;
        rem_q      <= rem_q - CNT_W'(1);
        {x_q, y_q} <= ctr_inc;
        k_q        <= key_q[WORD_W-1:0];
        l0_q       <= key_q[2*WORD_W-1:WORD_W];
        l1_q       <= key_q[3*WORD_W-1:2*WORD_W];
        l2_q       <= key_q[4*WORD_W-1:3*WORD_W];
        rnd_q      <= '0;
      end else if (step) begin
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        k_q   <= k_nxt;
        l0_q  <= l1_q;
        l1_q  <= l2_q;
        l2_q  <= l_nxt;
        rnd_q <= rnd_q + RND_W'(1);
      end
      if (take_in) out_q <= in_data ^ {x_q, y_q};
    end
  end

  // Sticky error: set by bad length or counter wrap, cleared only by an accepted start
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign in_ready  = (state_q == ST_WAIT_IN) && !abort;
  assign out_valid = (state_q == ST_OUT) && !abort;
  assign out_data  = out_valid ? out_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_ttc3_ctr_stream.sv
// Randomized self-checking bench for ttc3_ctr_stream against a behavioural SPECK64/128 CTR model.
// Latency: checks start->out_valid and start->done cycle counts on directed requests.
// Backpressure: random in_valid/out_ready stalls; abort during keystream and during a held output.
module tb_ttc3_ctr_stream;

  localparam int BLK_W = 64;
  localparam int KEY_W = 128;
  localparam int CNT_W = 5;
  localparam logic [KEY_W-1:0] VK = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [BLK_W-1:0] VC = 64'h3b726574_7475432d;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [KEY_W-1:0] key;
  logic [BLK_W-1:0] ctr_init;
  logic [CNT_W-1:0] num_blocks;
  logic             abort;
  logic [BLK_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;

  int n_chk = 0;
  int n_bad = 0;

  ttc3_ctr_stream #(.WORD_W(32), .ROUNDS(27), .MAX_BLOCKS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .ctr_init   (ctr_init),
    .num_blocks (num_blocks),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SPECK64/128 encryption: full round-key table first, then the 27 rounds
  function automatic logic [63:0] speck64(input logic [127:0] kk, input logic [63:0] pt);
    logic [31:0] rk[27];
    logic [31:0] l[30];
    logic [31:0] x, y;
    rk[0] = kk[31:0];
    l[0]  = kk[63:32];
    l[1]  = kk[95:64];
    l[2]  = kk[127:96];
    for (int i = 0; i < 26; i++) begin
      l[i+3]  = (rk[i] + {l[i][7:0], l[i][31:8]}) ^ 32'(i);
      rk[i+1] = {rk[i][28:0], rk[i][31:29]} ^ l[i+3];
    end
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 0; i < 27; i++) begin
      x = ({x[7:0], x[31:8]} + y) ^ rk[i];
      y = {y[28:0], y[31:29]} ^ x;
    end
    return {x, y};
  endfunction

  int r_nin, r_nout, r_lat, r_ldone;
  logic [63:0] r_first;

  // Drives one request from a negedge in IDLE; returns at the negedge after done (back in IDLE)
  task automatic do_req(input logic [127:0] k, input logic [63:0] c, input int num,
                        input int vpct, input int rpct, input bit zero_in,
                        input int abort_cyc, input bit abort_out);
    logic [63:0] exp_q[$];
    int cyc;
    bit aborted;
    bit fin;
    r_nin = 0; r_nout = 0; r_lat = -1; r_ldone = -1; r_first = '0;
    aborted = 0; fin = 0;
    key = k; ctr_init = c; num_blocks = CNT_W'(num); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      if (done) begin
        r_ldone = cyc;
        chk("zeroized_regs", 64'((|dut.key_q) | (|dut.x_q) | (|dut.y_q) | (|dut.k_q) | (|dut.l0_q)
                               | (|dut.l1_q) | (|dut.l2_q) | (|dut.ctr_q) | (|dut.out_q)), 64'd0);
        fin = 1;
      end else begin
        if (out_valid) begin
          if (r_lat < 0) begin r_lat = cyc; r_first = out_data; end
          if (aborted || exp_q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
          else chk("out_data", out_data, exp_q[0]);
        end else begin
          chk("out_data_idle_zero", out_data, 64'd0);
        end
        if (aborted && in_ready) chk("in_ready_after_abort", 64'd1, 64'd0);
        abort     = (cyc == abort_cyc) || (abort_out && out_valid && !aborted);
        in_valid  = ($urandom_range(99) < vpct);
        in_data   = zero_in ? 64'd0 : {$urandom, $urandom};
        out_ready = abort_out ? 1'b0 : ($urandom_range(99) < rpct);
        if (!abort) begin
          if (in_ready && in_valid) begin
            exp_q.push_back(in_data ^ speck64(k, c + 64'(r_nin)));
            r_nin++;
          end
          if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            r_nout++;
          end
        end else begin
          aborted = 1;
          exp_q.delete();
        end
        @(negedge clock);
        abort = 1'b0;
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 64'd0, 64'd1);
    chk("pending_blocks", 64'(exp_q.size()), 64'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [127:0] rk;
    logic [63:0]  rc;
    int rn, seen, cyc;
    reset = 1'b1; start = 1'b0; key = '0; ctr_init = '0; num_blocks = '0;
    abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Published test vector, full-speed streaming
    do_req(VK, VC, 1, 100, 100, 1'b1, -1, 1'b0);
    chk("t1_out", r_first, 64'h8c6fa548_454e028b);
    chk("t1_latency", 64'(r_lat), 64'd29);
    chk("t1_done_cyc", 64'(r_ldone), 64'd31);
    chk("t1_err", 64'(err), 64'd0);

    // Three blocks under random stalls
    do_req(VK, VC, 3, 50, 50, 1'b0, -1, 1'b0);
    chk("t2_nout", 64'(r_nout), 64'd3);
    chk("t2_err", 64'(err), 64'd0);

    // Random keys, counters and lengths
    for (int t = 0; t < 5; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = {1'b0, 31'($urandom), $urandom};
      rn = $urandom_range(16, 1);
      do_req(rk, rc, rn, 70, 70, 1'b0, -1, 1'b0);
      chk("rand_nout", 64'(r_nout), 64'(rn));
      chk("rand_nin", 64'(r_nin), 64'(rn));
      chk("rand_err", 64'(err), 64'd0);
    end

    // Illegal lengths
    do_req(VK, VC, 0, 100, 100, 1'b0, -1, 1'b0);
    chk("len0_nin", 64'(r_nin), 64'd0);
    chk("len0_done_cyc", 64'(r_ldone), 64'd2);
    chk("len0_err", 64'(err), 64'd1);
    do_req(VK, VC, 17, 100, 100, 1'b0, -1, 1'b0);
    chk("len17_nin", 64'(r_nin), 64'd0);
    chk("len17_done_cyc", 64'(r_ldone), 64'd2);
    chk("len17_err", 64'(err), 64'd1);

    // Counter wrap
    do_req(VK, 64'hFFFF_FFFF_FFFF_FFFF, 2, 80, 80, 1'b0, -1, 1'b0);
`ifdef TTC3_CTR_WRAP_ALLOW_EN
    chk("wrap_nout", 64'(r_nout), 64'd2);
    chk("wrap_err", 64'(err), 64'd0);
`else
    chk("wrap_nout", 64'(r_nout), 64'd1);
    chk("wrap_err", 64'(err), 64'd1);
`endif

    // Abort at keystream round 10, then abort while an output is held
    do_req(VK, VC, 2, 100, 100, 1'b0, 11, 1'b0);
    chk("abort_ks_nout", 64'(r_nout), 64'd0);
    chk("abort_ks_done_cyc", 64'(r_ldone), 64'd13);
    chk("abort_ks_err", 64'(err), 64'd0);
    do_req(VK, VC, 2, 100, 0, 1'b0, -1, 1'b1);
    chk("abort_out_nout", 64'(r_nout), 64'd0);
    chk("abort_out_done_cyc", 64'(r_ldone), 64'(r_lat + 2));
    chk("abort_out_err", 64'(err), 64'd0);
    do_req(VK, VC, 1, 100, 100, 1'b1, -1, 1'b0);
    chk("post_abort_out", r_first, 64'h8c6fa548_454e028b);
    chk("post_abort_latency", 64'(r_lat), 64'd29);

    // Reset while waiting for the second block's input
    key = VK; ctr_init = VC; num_blocks = CNT_W'(3); start = 1'b1;
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 500) begin
      if (in_ready) seen++;
      if (seen < 2) begin
        @(negedge clock);
        cyc++;
      end
    end
    chk("rst_reach_blk2", 64'(seen), 64'd2);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mid_out", {out_data[62:0], out_valid}, 64'd0);
    chk("rst_mid_busy_err", 64'({busy, err}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_done", 64'(done), 64'd0);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_release_idle", 64'({busy, done}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
